// File: rtl/pwm_fault_guard_pkg.sv
// Shared types and constants for the pwm_fault_guard channel protection slice.
// Holds the channel state encoding, leg indices and a counter-width helper.
package pwm_fault_guard_pkg;

  typedef enum logic [1:0] {
    NORMAL  = 2'b01,
    PROTECT = 2'b10,
    LOCKOUT = 2'b11
  } state_t;

  localparam int unsigned LL = 0;
  localparam int unsigned LH = 1;
  localparam int unsigned RL = 2;
  localparam int unsigned RH = 3;

  // Width needed to hold 0..max_val, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    int unsigned w;
    w = $clog2(max_val + 1);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/pwm_guard_ch.sv
// One full-bridge channel: fault filter/trip FSM, retry window, edge detect, gating.
// Define ST_LATCH_EN to make a shoot-through pattern an immediate trip.
module pwm_guard_ch
  import pwm_fault_guard_pkg::*;
#(
  parameter int unsigned N_FLT     = 2,
  parameter int unsigned FILT_CYC  = 4,
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned WIN_CYC   = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       pwm_in,
  input  logic [N_FLT-1:0] flt_n,
  input  logic             rearm_en,
  input  logic             clr,
  output logic [3:0]       pwm_out,
  output logic             ch_ok,
  output logic             lockout,
  output logic [N_FLT-1:0] trip_cause
);

  localparam int unsigned FW = cnt_w(FILT_CYC - 1);
  localparam int unsigned RW = cnt_w(MAX_RETRY);
  localparam int unsigned WW = cnt_w(WIN_CYC - 1);

  state_t           state;
  state_t           state_nxt;
  logic [FW-1:0]    filt_cnt;
  logic [RW-1:0]    retry_cnt;
  logic [WW-1:0]    win_cnt;
  logic             lh_s1;
  logic             lh_s2;
  logic             rh_s1;
  logic             rh_s2;
  logic             flt_any;
  logic             st;
  logic             rise;
  logic             trip_flt;
  logic             trip_st;
  logic             trip;
  logic             rearm_ok;
  logic             retry_full;
  logic [N_FLT-1:0] cause_trip;

  assign flt_any    = ~&flt_n;
  assign st         = (pwm_in[LL] & pwm_in[LH]) | (pwm_in[RL] & pwm_in[RH]);
  assign rise       = (lh_s1 & ~lh_s2) | (rh_s1 & ~rh_s2);
  assign trip_flt   = flt_any && (filt_cnt == FW'(FILT_CYC - 1));
`ifdef ST_LATCH_EN
  assign trip_st    = st;
`else
  assign trip_st    = 1'b0;
`endif
  assign trip       = trip_flt | trip_st;
  assign rearm_ok   = rearm_en & rise & ~flt_any;
  assign retry_full = (retry_cnt == RW'(MAX_RETRY));

  // A shoot-through trip marks bit 0 on top of whatever cause is being latched.
  always_comb begin
    cause_trip = trip_flt ? ~flt_n : trip_cause;
    if (trip_st) cause_trip[0] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= NORMAL;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      NORMAL:  if (!clr && trip) state_nxt = PROTECT;
      PROTECT: begin
        if (clr)           state_nxt = NORMAL;
        else if (rearm_ok) state_nxt = retry_full ? LOCKOUT : NORMAL;
      end
      LOCKOUT: if (clr) state_nxt = NORMAL;
      default: state_nxt = PROTECT;
    endcase
  end

  always_comb begin
    ch_ok   = 1'b0;
    lockout = 1'b0;
    case (state)
      NORMAL:  ch_ok   = 1'b1;
      LOCKOUT: lockout = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      filt_cnt   <= '0;
      retry_cnt  <= '0;
      win_cnt    <= '0;
      trip_cause <= '0;
      lh_s1      <= 1'b0;
      lh_s2      <= 1'b0;
      rh_s1      <= 1'b0;
      rh_s2      <= 1'b0;
    end else begin
      lh_s1 <= pwm_in[LH];
      lh_s2 <= lh_s1;
      rh_s1 <= pwm_in[RH];
      rh_s2 <= rh_s1;
      case (state)
        NORMAL: begin
          if (!flt_any)                             filt_cnt <= '0;
          else if (filt_cnt != FW'(FILT_CYC - 1))   filt_cnt <= filt_cnt + FW'(1);
          if (win_cnt == WW'(WIN_CYC - 1)) retry_cnt <= '0;
          else                             win_cnt   <= win_cnt + WW'(1);
          if (clr) begin
            trip_cause <= '0;
          end else if (trip) begin
            filt_cnt   <= '0;
            trip_cause <= cause_trip;
          end
        end
        PROTECT: begin
          filt_cnt <= '0;
          win_cnt  <= '0;
          if (clr) begin
            retry_cnt  <= '0;
            trip_cause <= '0;
          end else if (rearm_ok && !retry_full) begin
            retry_cnt <= retry_cnt + RW'(1);
          end
        end
        LOCKOUT: begin
          filt_cnt <= '0;
          win_cnt  <= '0;
          if (clr) begin
            retry_cnt  <= '0;
            trip_cause <= '0;
          end
        end
        default: begin
          filt_cnt <= '0;
          win_cnt  <= '0;
        end
      endcase
    end
  end

  // Low sides pass untouched; high sides need an enabled channel and no overlap.
  assign pwm_out[LL] = pwm_in[LL];
  assign pwm_out[RL] = pwm_in[RL];
  assign pwm_out[LH] = pwm_in[LH] & ch_ok & ~st;
  assign pwm_out[RH] = pwm_in[RH] & ch_ok & ~st;

endmodule

// File: rtl/pwm_fault_guard.sv
// N-channel full-bridge PWM protection gate; one pwm_guard_ch per channel.
// Define ST_LATCH_EN to make a shoot-through pattern an immediate trip.
module pwm_fault_guard
  import pwm_fault_guard_pkg::*;
#(
  parameter int unsigned N_CH      = 2,
  parameter int unsigned N_FLT     = 2,
  parameter int unsigned FILT_CYC  = 4,
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned WIN_CYC   = 1000
) (
  input  logic                  CLK_50M,
  input  logic                  Rst,
  input  logic [4*N_CH-1:0]     pwm_in,
  input  logic [N_FLT*N_CH-1:0] flt_n,
  input  logic [N_CH-1:0]       rearm_en,
  input  logic [N_CH-1:0]       clr,
  output logic [4*N_CH-1:0]     pwm_out,
  output logic [N_CH-1:0]       ch_ok,
  output logic [N_CH-1:0]       lockout,
  output logic [N_FLT*N_CH-1:0] trip_cause
);

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    pwm_guard_ch #(
      .N_FLT    (N_FLT),
      .FILT_CYC (FILT_CYC),
      .MAX_RETRY(MAX_RETRY),
      .WIN_CYC  (WIN_CYC)
    ) u_ch (
      .clk       (CLK_50M),
      .rst       (Rst),
      .pwm_in    (pwm_in[4*c +: 4]),
      .flt_n     (flt_n[N_FLT*c +: N_FLT]),
      .rearm_en  (rearm_en[c]),
      .clr       (clr[c]),
      .pwm_out   (pwm_out[4*c +: 4]),
      .ch_ok     (ch_ok[c]),
      .lockout   (lockout[c]),
      .trip_cause(trip_cause[N_FLT*c +: N_FLT])
    );
  end

endmodule
